// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types for the player sprite animation sequencer
// Also used by the color-mapper palette mux to decode sprite_sel.
package anim_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_ATTACK,
      ST_COOLDOWN
   } anim_state_t;

   typedef struct packed {
      logic       attack;
      dir_t       dir;
      logic [1:0] frame;
   } sprite_sel_t;

   localparam sprite_sel_t SPRITE_SEL_RESET = '{attack: 1'b0, dir: DIR_DOWN, frame: 2'd0};

   localparam logic [1:0] ATK_LAST_FRAME = 2'd3;

   // Shared width for the hold and cooldown counters; never narrower than 1 bit.
   function automatic int cnt_width(input int walk_hold, input int atk_hold, input int atk_cool);
      int m;
      m = 2;
      if (walk_hold > m) m = walk_hold;
      if (atk_hold > m)  m = atk_hold;
      if (atk_cool > m)  m = atk_cool;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/anim_hold_counter.sv
// rtl/anim_hold_counter.sv - frame-tick counter with clear, enable and terminal-count flag
// The owner decides when to clear; the counter itself never wraps.
module anim_hold_counter #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic         tc_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == term_i);

endmodule

// File: rtl/link_anim_sequencer.sv
// rtl/link_anim_sequencer.sv - walk / sword-swing animation FSM for the player sprite
// Advances only on frame ticks; every output is registered from next-state values.
module link_anim_sequencer
   import anim_pkg::*;
#(
   parameter int WALK_HOLD    = 8,
   parameter int ATK_HOLD     = 4,
   parameter int ATK_COOLDOWN = 6
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic [1:0] dir_in,
   input  logic       move,
   input  logic       attack_req,
   output logic [4:0] sprite_sel,
   output logic       attack_active,
   output logic       attack_done,
   output logic       busy
);

   localparam int CW = cnt_width(WALK_HOLD, ATK_HOLD, ATK_COOLDOWN);
   localparam logic [CW-1:0] WALK_TERM = CW'(WALK_HOLD - 1);
   localparam logic [CW-1:0] ATK_TERM  = CW'(ATK_HOLD - 1);
   localparam logic [CW-1:0] COOL_TERM = CW'((ATK_COOLDOWN > 0) ? ATK_COOLDOWN - 1 : 0);

   anim_state_t state_q, state_d;
   dir_t        dir_q, dir_d;
   logic [1:0]  frame_q, frame_d;
   sprite_sel_t sel_q;
   logic        active_q, done_q, done_d, busy_q;

   logic          hold_clr, hold_en, hold_tc;
   logic          cool_clr, cool_en, cool_tc;
   logic [CW-1:0] hold_term;

   // One hold counter serves both walk and swing; only its terminal value changes.
   assign hold_term = (state_q == ST_ATTACK) ? ATK_TERM : WALK_TERM;

   anim_hold_counter #(.W(CW)) u_hold (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (hold_clr),
      .en_i   (hold_en),
      .term_i (hold_term),
      .tc_o   (hold_tc)
   );

   anim_hold_counter #(.W(CW)) u_cool (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (cool_clr),
      .en_i   (cool_en),
      .term_i (COOL_TERM),
      .tc_o   (cool_tc)
   );

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      frame_d  = frame_q;
      done_d   = 1'b0;
      hold_clr = 1'b0;
      hold_en  = 1'b0;
      cool_clr = 1'b0;
      cool_en  = 1'b0;

      if (state_q != ST_ATTACK && move) begin
         dir_d = dir_t'(dir_in);
      end

      case (state_q)
         ST_IDLE: begin
            frame_d = 2'd0;
            if (attack_req) begin
               state_d  = ST_ATTACK;
               hold_clr = 1'b1;
            end else if (move) begin
               state_d  = ST_WALK;
               hold_clr = 1'b1;
            end
         end

         ST_WALK: begin
            // A request beats both a coincident tick and a released key.
            if (attack_req) begin
               state_d  = ST_ATTACK;
               frame_d  = 2'd0;
               hold_clr = 1'b1;
            end else if (!move) begin
               state_d = ST_IDLE;
               frame_d = 2'd0;
            end else if (frame_tick) begin
               if (hold_tc) begin
                  hold_clr = 1'b1;
                  frame_d  = {1'b0, ~frame_q[0]};
               end else begin
                  hold_en = 1'b1;
               end
            end
         end

         ST_ATTACK: begin
            if (frame_tick) begin
               if (hold_tc) begin
                  hold_clr = 1'b1;
                  if (frame_q == ATK_LAST_FRAME) begin
                     done_d  = 1'b1;
                     frame_d = 2'd0;
                     if (ATK_COOLDOWN > 0) begin
                        state_d  = ST_COOLDOWN;
                        cool_clr = 1'b1;
                     end else begin
                        state_d = move ? ST_WALK : ST_IDLE;
                     end
                  end else begin
                     frame_d = frame_q + 2'd1;
                  end
               end else begin
                  hold_en = 1'b1;
               end
            end
         end

         ST_COOLDOWN: begin
            frame_d = 2'd0;
            if (frame_tick) begin
               if (cool_tc) begin
                  state_d  = move ? ST_WALK : ST_IDLE;
                  cool_clr = 1'b1;
                  hold_clr = 1'b1;
               end else begin
                  cool_en = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            frame_d = 2'd0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_DOWN;
         frame_q  <= 2'd0;
         sel_q    <= SPRITE_SEL_RESET;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         frame_q  <= frame_d;
         sel_q    <= '{attack: (state_d == ST_ATTACK), dir: dir_d, frame: frame_d};
         active_q <= (state_d == ST_ATTACK);
         done_q   <= done_d;
         busy_q   <= (state_d == ST_ATTACK) || (state_d == ST_COOLDOWN);
      end
   end

   assign sprite_sel    = sel_q;
   assign attack_active = active_q;
   assign attack_done   = done_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_link_anim_sequencer.sv
// tb/tb_link_anim_sequencer.sv - randomized bench against a tick-counting model, two cooldown builds
module tb_link_anim_sequencer;

   localparam int WH = 8;
   localparam int AH = 4;
   localparam int M_IDLE = 0, M_WALK = 1, M_ATK = 2, M_COOL = 3;

   logic       Clk = 1'b0;
   logic       Reset_n, frame_tick, move, attack_req;
   logic [1:0] dir_in;
   logic [4:0] sel [2];
   logic       act [2], done [2], busy [2];

   int checks = 0, failures = 0;
   logic chk_en = 1'b0;

   // Model: whole-phase tick totals rather than per-pose counters.
   int         mode [2], wt [2], at [2], ct [2];
   logic [1:0] mdir [2];
   logic       mdone [2];

   always #5 Clk = ~Clk;

   link_anim_sequencer #(.WALK_HOLD(WH), .ATK_HOLD(AH), .ATK_COOLDOWN(6)) dut0 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .dir_in(dir_in), .move(move),
      .attack_req(attack_req), .sprite_sel(sel[0]), .attack_active(act[0]),
      .attack_done(done[0]), .busy(busy[0]));

   link_anim_sequencer #(.WALK_HOLD(WH), .ATK_HOLD(AH), .ATK_COOLDOWN(0)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .dir_in(dir_in), .move(move),
      .attack_req(attack_req), .sprite_sel(sel[1]), .attack_active(act[1]),
      .attack_done(done[1]), .busy(busy[1]));

   function automatic int ac_of(input int k);
      return (k == 0) ? 6 : 0;
   endfunction

   function automatic logic [4:0] exp_sel(input int k);
      int fr;
      fr = 0;
      if (mode[k] == M_ATK) fr = at[k] / AH;
      else if (mode[k] == M_WALK) fr = (wt[k] / WH) % 2;
      return {(mode[k] == M_ATK), mdir[k], 2'(fr)};
   endfunction

   task automatic check5(input string name, input logic [4:0] a, input logic [4:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, a, e, $time);
      end
   endtask

   task automatic check1(input string name, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, a, e, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mode[k] = M_IDLE; wt[k] = 0; at[k] = 0; ct[k] = 0;
         mdir[k] = 2'd1; mdone[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      if (!Reset_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         mdone[k] = 1'b0;
         if (mode[k] != M_ATK && move) mdir[k] = dir_in;
         case (mode[k])
            M_IDLE: begin
               if (attack_req) begin mode[k] = M_ATK; at[k] = 0; end
               else if (move) begin mode[k] = M_WALK; wt[k] = 0; end
            end
            M_WALK: begin
               if (attack_req) begin mode[k] = M_ATK; at[k] = 0; end
               else if (!move) mode[k] = M_IDLE;
               else if (frame_tick) wt[k] = (wt[k] + 1) % (2 * WH);
            end
            M_ATK: begin
               if (frame_tick) begin
                  at[k]++;
                  if (at[k] == 4 * AH) begin
                     mdone[k] = 1'b1;
                     if (ac_of(k) > 0) begin mode[k] = M_COOL; ct[k] = 0; end
                     else begin mode[k] = move ? M_WALK : M_IDLE; wt[k] = 0; end
                  end
               end
            end
            default: begin
               if (frame_tick) begin
                  ct[k]++;
                  if (ct[k] == ac_of(k)) begin mode[k] = move ? M_WALK : M_IDLE; wt[k] = 0; end
               end
            end
         endcase
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check5($sformatf("sel%0d", k), sel[k], exp_sel(k));
            check1($sformatf("active%0d", k), act[k], mode[k] == M_ATK);
            check1($sformatf("done%0d", k), done[k], mdone[k]);
            check1($sformatf("busy%0d", k), busy[k], mode[k] == M_ATK || mode[k] == M_COOL);
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0; frame_tick = 1'b0; move = 1'b0; attack_req = 1'b0; dir_in = 2'd0;
      model_reset();
      repeat (3) cyc();
      Reset_n = 1'b1;
      chk_en = 1'b1;

      // Idle after reset
      for (int i = 0; i < 100; i++) begin
         pulse_tick();
         cyc();
      end
      check5("idle_sel", sel[0], 5'b00100);
      check1("idle_busy", busy[0], 1'b0);

      // Walk cadence facing right
      dir_in = 2'd3; move = 1'b1;
      cyc();
      check5("walk_start", sel[0], 5'b01100);
      repeat (7) pulse_tick();
      check5("walk_t7", sel[0], 5'b01100);
      pulse_tick();
      check5("walk_t8", sel[0], 5'b01101);
      repeat (7) pulse_tick();
      check5("walk_t15", sel[0], 5'b01101);
      pulse_tick();
      check5("walk_t16", sel[0], 5'b01100);
      move = 1'b0;
      cyc();
      check5("walk_stop", sel[0], 5'b01100);

      // Face up, then swing; dir changes and a repeat request are ignored mid-swing
      dir_in = 2'd0; move = 1'b1;
      cyc();
      move = 1'b0;
      cyc();
      attack_req = 1'b1;
      cyc();
      attack_req = 1'b0;
      check5("atk_start", sel[0], 5'b10000);
      check1("atk_active", act[0], 1'b1);
      for (int i = 1; i <= 16; i++) begin
         dir_in = 2'($urandom_range(0, 3));
         move = (i < 12);
         attack_req = (i == 6);
         pulse_tick();
         if (i == 4)  check5("atk_f1", sel[0], 5'b10001);
         if (i == 8)  check5("atk_f2", sel[0], 5'b10010);
         if (i == 12) check5("atk_f3", sel[0], 5'b10011);
      end
      attack_req = 1'b0;
      check1("atk_done0", done[0], 1'b1);
      check5("cool_sel", sel[0], 5'b00000);
      check1("cool_busy", busy[0], 1'b1);
      check1("atk_done1", done[1], 1'b1);
      check1("nocool_busy", busy[1], 1'b0);
      for (int j = 1; j <= 6; j++) begin
         attack_req = (j == 2);
         pulse_tick();
         if (j == 5) check1("cool_t5_busy", busy[0], 1'b1);
         if (j == 6) check1("cool_t6_busy", busy[0], 1'b0);
      end
      attack_req = 1'b1;
      cyc();
      attack_req = 1'b0;
      check1("reatk_active", act[0], 1'b1);

      // Asynchronous reset in the middle of frame 2
      repeat (9) pulse_tick();
      check5("pre_rst_f2", sel[0], 5'b10010);
      #2 Reset_n = 1'b0;
      model_reset();
      #1;
      check5("rst_sel", sel[0], 5'b00100);
      check1("rst_active", act[0], 1'b0);
      check1("rst_done", done[0], 1'b0);
      repeat (2) cyc();
      Reset_n = 1'b1;

      // Request coincident with a tick and released key while walking left
      dir_in = 2'd2; move = 1'b1;
      cyc();
      repeat (3) pulse_tick();
      move = 1'b0; attack_req = 1'b1; frame_tick = 1'b1;
      cyc();
      attack_req = 1'b0; frame_tick = 1'b0;
      check1("coinc_active", act[0], 1'b1);
      check5("coinc_sel", sel[0], 5'b11000);
      repeat (3) pulse_tick();
      check5("coinc_t3", sel[0], 5'b11000);
      pulse_tick();
      check5("coinc_t4", sel[0], 5'b11001);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         frame_tick = ($urandom_range(0, 3) == 0);
         attack_req = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 15) == 0) move = ~move;
         dir_in = 2'($urandom_range(0, 3));
         cyc();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
